// File: rtl/pong_score_ctrl.sv
// Game-flow and score controller for the pong display path.
// Sequences a match through IDLE -> SERVE -> PLAY -> (SERVE | OVER) and owns
// both players' two-digit BCD scores. The displayed digits are snapshots of
// the working scores taken on frame_tick, so the renderer never sees a score
// change in the middle of a frame.
//
// Pulse semantics: start, p1_point, p2_point and frame_tick are single-cycle
// strobes sampled on the rising clock edge. There is no backpressure; a strobe
// that arrives in a state that does not use it is dropped.
module pong_score_ctrl #(
  parameter int WIN_TENS     = 1,
  parameter int WIN_ONES     = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       frame_tick,
  output logic [3:0] p1_score_d1,
  output logic [3:0] p1_score_d2,
  output logic [3:0] p2_score_d1,
  output logic [3:0] p2_score_d2,
  output logic       serve_en,
  output logic       game_over,
  output logic       winner
);

  // Serve counter only has to reach SERVE_FRAMES-1.
  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [7:0]    WIN_SCORE  = {4'(WIN_TENS), 4'(WIN_ONES)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] serve_cnt;

  // Working scores, packed as {tens, ones}.
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic [7:0] p1_next;
  logic [7:0] p2_next;

  // Two-digit BCD increment that saturates at 99. The ones digit wraps to 0
  // with a carry into tens, so no digit ever leaves the 0-9 range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] < 4'd9) begin
      r[3:0] = s[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      r[7:4] = s[7:4] + 4'd1;
    end
    return r;
  endfunction

  // Candidate post-point scores, used both to update and to test for a win.
  always_comb begin
    p1_next = bcd_inc(p1_score);
    p2_next = bcd_inc(p2_score);
  end

  // Match FSM with working scores, serve counter and registered state decodes.
  // serve_en / game_over are written alongside the state so they always equal
  // the decode of the state they accompany.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      serve_cnt <= '0;
      p1_score  <= 8'h00;
      p2_score  <= 8'h00;
      serve_en  <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Scores are already zero here: IDLE is only entered from reset.
          if (start) begin
            serve_cnt <= '0;
            state     <= SERVE;
          end
        end

        SERVE: begin
          // Points are dropped while the ball is being re-served.
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt <= '0;
              state     <= PLAY;
              serve_en  <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end

        PLAY: begin
          // Simultaneous points cancel out: nothing changes, play continues.
          if (p1_point && !p2_point) begin
            p1_score <= p1_next;
            serve_en <= 1'b0;
            if (p1_next == WIN_SCORE) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state     <= SERVE;
              serve_cnt <= '0;
            end
          end else if (p2_point && !p1_point) begin
            p2_score <= p2_next;
            serve_en <= 1'b0;
            if (p2_next == WIN_SCORE) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state     <= SERVE;
              serve_cnt <= '0;
            end
          end
        end

        OVER: begin
          // Rematch: fresh scores, straight into the serve delay. winner keeps
          // its last value until the next match ends.
          if (start) begin
            p1_score  <= 8'h00;
            p2_score  <= 8'h00;
            serve_cnt <= '0;
            state     <= SERVE;
            game_over <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          serve_en <= 1'b0;
        end
      endcase
    end
  end

  // Display snapshot: load the working scores as they stood before this edge,
  // once per frame, so digits only change during vblank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_score_d1 <= 4'd0;
      p1_score_d2 <= 4'd0;
      p2_score_d1 <= 4'd0;
      p2_score_d2 <= 4'd0;
    end else if (frame_tick) begin
      p1_score_d1 <= p1_score[7:4];
      p1_score_d2 <= p1_score[3:0];
      p2_score_d1 <= p2_score[7:4];
      p2_score_d2 <= p2_score[3:0];
    end
  end

endmodule
